// File: rtl/instr_in_buffer_if.sv
// Handshake bundle between fetch, the instruction buffer and decode.
// The master modport is the environment side; the slave modport is the buffer.
interface instr_in_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic            flush;
    logic [CW-1:0]   count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc, out_illegal, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc, out_illegal, count
    );
endinterface

// File: rtl/instr_in_buffer.sv
// First-word fall-through FIFO of {instr, pc} pairs between fetch and decode.
// Flush (taken branch) drops all entries; ready/valid come only from registered count.
module instr_in_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input logic              clk,
    input logic              rst,
    instr_in_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;

    assign in_ready   = (count_q != CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign push       = bus.in_valid && in_ready && !bus.flush;
    assign pop        = out_valid && bus.out_ready && !bus.flush;
    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.in_instr;
            pc_mem_q[wr_ptr_q]    <= bus.in_pc;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_valid ? head_instr : NOP;
    assign bus.out_pc      = out_valid ? head_pc : '0;
    assign bus.out_illegal = out_valid && (head_instr[1:0] != 2'b11);
    assign bus.count       = count_q;
endmodule

// File: tb/tb_instr_in_buffer.sv
// Self-checking bench for instr_in_buffer: directed vector table plus a
// scoreboard of accepted {instr, pc} pairs compared at each decoder handshake.
module tb_instr_in_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    ent_t sb[$];
    vec_t vecs[$];

    instr_in_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    instr_in_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; scoreboard compares pre-edge head on handshake, then advances the model.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
        ent_t e;
        bit   full;
        rst           = r;
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        #1;
        full = (sb.size() == DEPTH);
        if (r || f) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && ordy) begin
                e = sb.pop_front();
                pops++;
                chk("sb_out_valid", 32'(bus.out_valid), 32'd1);
                chk("sb_out_instr", bus.out_instr, e.instr);
                chk("sb_out_pc",    bus.out_pc,    e.pc);
            end
            if (iv && !full) begin
                e.instr = ins;
                e.pc    = pc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("model_count", 32'(bus.count), 32'(sb.size()));
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [31:0] ins, input logic [31:0] pc, input logic ordy,
                                input logic [2:0] ec, input logic eov, input logic eir,
                                input logic [31:0] ei, input logic [31:0] ep, input logic eil);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.instr = ins; v.pc = pc; v.ordy = ordy;
        v.e_cnt = ec; v.e_ov = eov; v.e_ir = eir; v.e_instr = ei; v.e_pc = ep; v.e_ill = eil;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        //                r  f  iv instr          pc     ordy cnt ov ir e_instr        e_pc   ill
        vecs.push_back(mk(1, 0, 0, 32'h0,         32'd0,  0,  0, 0, 1, NOP,           32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00500093,  32'd0,  0,  1, 1, 1, 32'h00500093,  32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00100113,  32'd4,  0,  2, 1, 1, 32'h00500093,  32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00200193,  32'd8,  0,  3, 1, 1, 32'h00500093,  32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00300213,  32'd12, 0,  4, 1, 0, 32'h00500093,  32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'hdeadbeef,  32'd99, 0,  4, 1, 0, 32'h00500093,  32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00400293,  32'd16, 1,  3, 1, 1, 32'h00100113,  32'd4,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00400293,  32'd16, 1,  3, 1, 1, 32'h00200193,  32'd8,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'd0,  1,  2, 1, 1, 32'h00300213,  32'd12, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'd0,  1,  1, 1, 1, 32'h00400293,  32'd16, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'd0,  1,  0, 0, 1, NOP,           32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00000513,  32'd20, 0,  1, 1, 1, 32'h00000513,  32'd20, 0));
        vecs.push_back(mk(0, 0, 1, 32'h00000593,  32'd24, 0,  2, 1, 1, 32'h00000513,  32'd20, 0));
        vecs.push_back(mk(0, 0, 1, 32'h00000613,  32'd28, 0,  3, 1, 1, 32'h00000513,  32'd20, 0));
        vecs.push_back(mk(0, 1, 1, 32'h00000693,  32'd32, 1,  0, 0, 1, NOP,           32'd0,  0));
        vecs.push_back(mk(0, 0, 1, 32'h00000000,  32'd36, 0,  1, 1, 1, 32'h00000000,  32'd36, 1));
        vecs.push_back(mk(0, 0, 1, 32'h00000713,  32'd40, 0,  2, 1, 1, 32'h00000000,  32'd36, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'd0,  1,  1, 1, 1, 32'h00000713,  32'd40, 0));
        vecs.push_back(mk(0, 0, 1, 32'h00000793,  32'd44, 0,  2, 1, 1, 32'h00000713,  32'd40, 0));
        vecs.push_back(mk(1, 0, 1, 32'h00000813,  32'd48, 1,  0, 0, 1, NOP,           32'd0,  0));

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy);
            chk($sformatf("v%0d_count", i),     32'(bus.count),       32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid),   32'(vecs[i].e_ov));
            chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),    32'(vecs[i].e_ir));
            chk($sformatf("v%0d_out_instr", i), bus.out_instr,        vecs[i].e_instr);
            chk($sformatf("v%0d_out_pc", i),    bus.out_pc,           vecs[i].e_pc);
            chk($sformatf("v%0d_illegal", i),   32'(bus.out_illegal), 32'(vecs[i].e_ill));
        end

        // Wrap-around: six pushes, popping one per cycle from the second cycle on.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
        pops = 0;
        for (int unsigned k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h00000093 | (k << 20), 32'(4 * k), (k != 0));
            chk($sformatf("wrap_count%0d", k), 32'(bus.count), 32'd1);
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
            n++;
        end
        chk("wrap_drained_entries", 32'(sb.size()), 32'd0);
        chk("wrap_pop_total", 32'(pops), 32'd6);
        chk("wrap_empty_out_valid", 32'(bus.out_valid), 32'd0);

        // Fill completely across the wrapped pointers, then drain in order.
        for (int unsigned k = 0; k < DEPTH; k++)
            cycle(1'b0, 1'b0, 1'b1, 32'h00001013 + (k << 8), 32'h100 + 32'(4 * k), 1'b0);
        chk("refill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("refill_head_pc", bus.out_pc, 32'h100);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
            n++;
        end
        chk("refill_drained", 32'(sb.size()), 32'd0);
        chk("refill_out_instr_nop", bus.out_instr, NOP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
